// File: rtl/tensor_core_controller.sv
// rtl/tensor_core_controller.sv - tensor core operand/result storage, burst access and 3x3 MAC sequencer
//
// Decodes the 16-bit word stream (opcode in [1:0]). The controller holds the
// 3x3 signed 8-bit matrices A, B and C. BURST moves A/B in and C out, and
// OPERATE computes C = A x B with one multiply-accumulate per clock.
//
// Ports:
//   clock_in                         system clock
//   reset_in                         asynchronous active-high reset
//   current_tensor_core_instruction  instruction or data word, one per clock
//   tensor_core_controller_output    registered C element from burst reads
//   busy                             high while a multiply is in progress
//   done                             one-cycle pulse when C is complete
//   error_sticky                     a non-NOP word was dropped while busy
module tensor_core_controller #(
    parameter int MAC_WIDTH  = 18,
    parameter int SAT_ENABLE = 1
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic [15:0]       current_tensor_core_instruction,
    output logic signed [7:0] tensor_core_controller_output,
    output logic              busy,
    output logic              done,
    output logic              error_sticky
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURST_W,
        S_BURST_R,
        S_BURST_RW,
        S_MAC
    } state_t;

    localparam logic signed [MAC_WIDTH-1:0] LP_SAT_MAX = MAC_WIDTH'(127);
    localparam logic signed [MAC_WIDTH-1:0] LP_SAT_MIN = MAC_WIDTH'(-128);

    state_t r_state;
    state_t w_next_state;

    logic signed [7:0] r_a [0:8];
    logic signed [7:0] r_b [0:8];
    logic signed [7:0] r_c [0:8];

    logic signed [7:0]           r_out;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_err;
    logic [3:0]                  r_idx;
    logic [3:0]                  r_rem;
    logic [1:0]                  r_mi;
    logic [1:0]                  r_mj;
    logic [1:0]                  r_mk;
    logic signed [MAC_WIDTH-1:0] r_acc;

    logic [15:0] w_word;
    logic [1:0]  w_opcode;
    logic [1:0]  w_sel;
    logic [3:0]  w_hdr_count;
    logic [3:0]  w_hdr_start;
    logic        w_soft_reset;
    logic        w_start_mac;
    logic        w_start_burst;
    logic        w_burst_write;
    logic        w_burst_read;
    logic        w_in_burst;
    logic        w_in_mac;
    logic        w_drop;
    logic        w_mac_last;

    logic [3:0]                  w_a_idx;
    logic [3:0]                  w_b_idx;
    logic [3:0]                  w_c_idx;
    logic signed [15:0]          w_prod;
    logic signed [MAC_WIDTH-1:0] w_prod_ext;
    logic signed [MAC_WIDTH-1:0] w_acc_base;
    logic signed [MAC_WIDTH-1:0] w_sum;
    logic signed [7:0]           w_c_val;

    assign w_word      = current_tensor_core_instruction;
    assign w_opcode    = w_word[1:0];
    assign w_sel       = w_word[3:2];
    assign w_hdr_count = (w_word[7:4] == 4'd0 || w_word[7:4] > 4'd9) ? 4'd9 : w_word[7:4];
    assign w_hdr_start = (w_word[11:8] > 4'd8) ? 4'd0 : w_word[11:8];
    assign w_mac_last  = (r_mi == 2'd2) && (r_mj == 2'd2) && (r_mk == 2'd2);

    // The RESET opcode is honoured wherever the word is not operand data. In
    // write and read+write phases the low byte is a B element, so B values
    // such as 3 or 7 must not be mistaken for RESET.
    assign w_soft_reset = (w_opcode == 2'b11) &&
                          (r_state == S_IDLE || r_state == S_MAC || r_state == S_BURST_R);

    always_comb begin
        w_next_state  = r_state;
        w_start_mac   = 1'b0;
        w_start_burst = 1'b0;
        w_burst_write = 1'b0;
        w_burst_read  = 1'b0;
        w_in_burst    = 1'b0;
        w_in_mac      = 1'b0;
        w_drop        = 1'b0;
        if (w_soft_reset) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_opcode == 2'b01) begin
                        w_start_mac  = 1'b1;
                        w_next_state = S_MAC;
                    end else if (w_opcode == 2'b10 && w_sel != 2'b11) begin
                        w_start_burst = 1'b1;
                        case (w_sel)
                            2'b00:   w_next_state = S_BURST_R;
                            2'b01:   w_next_state = S_BURST_W;
                            default: w_next_state = S_BURST_RW;
                        endcase
                    end
                end
                S_BURST_W, S_BURST_R, S_BURST_RW: begin
                    w_in_burst    = 1'b1;
                    w_burst_write = (r_state != S_BURST_R);
                    w_burst_read  = (r_state != S_BURST_W);
                    if (r_rem == 4'd1) begin
                        w_next_state = S_IDLE;
                    end
                end
                S_MAC: begin
                    w_in_mac = 1'b1;
                    // A select-11 BURST header is a NOP, so it is not an error.
                    w_drop   = (w_opcode == 2'b01) || (w_opcode == 2'b10 && w_sel != 2'b11);
                    if (w_mac_last) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // MAC datapath: A[i*3+k] * B[k*3+j], with k innermost
    assign w_a_idx    = {2'b00, r_mi} * 4'd3 + {2'b00, r_mk};
    assign w_b_idx    = {2'b00, r_mk} * 4'd3 + {2'b00, r_mj};
    assign w_c_idx    = {2'b00, r_mi} * 4'd3 + {2'b00, r_mj};
    assign w_prod     = r_a[w_a_idx] * r_b[w_b_idx];
    assign w_prod_ext = MAC_WIDTH'(w_prod);
    assign w_acc_base = (r_mk == 2'd0) ? LP_SAT_MAX - LP_SAT_MAX : r_acc;
    assign w_sum      = w_acc_base + w_prod_ext;

    always_comb begin
        w_c_val = w_sum[7:0];
        if (SAT_ENABLE != 0) begin
            if (w_sum > LP_SAT_MAX) begin
                w_c_val = 8'sd127;
            end else if (w_sum < LP_SAT_MIN) begin
                w_c_val = -8'sd128;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int n = 0; n < 9; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
                r_c[n] <= '0;
            end
            r_out  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_idx  <= '0;
            r_rem  <= '0;
            r_mi   <= '0;
            r_mj   <= '0;
            r_mk   <= '0;
            r_acc  <= '0;
        end else if (w_soft_reset) begin
            for (int n = 0; n < 9; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
                r_c[n] <= '0;
            end
            r_out  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_idx  <= '0;
            r_rem  <= '0;
            r_mi   <= '0;
            r_mj   <= '0;
            r_mk   <= '0;
            r_acc  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_mac) begin
                r_busy <= 1'b1;
                r_mi   <= '0;
                r_mj   <= '0;
                r_mk   <= '0;
            end
            if (w_start_burst) begin
                r_idx <= w_hdr_start;
                r_rem <= w_hdr_count;
            end
            if (w_burst_write) begin
                r_a[r_idx] <= w_word[15:8];
                r_b[r_idx] <= w_word[7:0];
            end
            if (w_burst_read) begin
                r_out <= r_c[r_idx];
            end
            if (w_in_burst) begin
                r_idx <= (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;
                r_rem <= r_rem - 4'd1;
            end
            if (w_in_mac) begin
                if (w_drop) begin
                    r_err <= 1'b1;
                end
                r_acc <= w_sum;
                if (r_mk == 2'd2) begin
                    r_c[w_c_idx] <= w_c_val;
                    r_mk <= 2'd0;
                    if (r_mj == 2'd2) begin
                        r_mj <= 2'd0;
                        r_mi <= r_mi + 2'd1;
                    end else begin
                        r_mj <= r_mj + 2'd1;
                    end
                end else begin
                    r_mk <= r_mk + 2'd1;
                end
                if (w_mac_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign tensor_core_controller_output = r_out;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error_sticky = r_err;

endmodule
